// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one clocked ALU between NUM_REQ requesters,
// returning each 33-bit result through a per-requester response handshake.
module alu_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_operand1,
    input  logic [32*NUM_REQ-1:0] req_operand2,
    input  logic [4*NUM_REQ-1:0]  req_opcode,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [32:0]           resp_result,
    output logic                  resp_error,
    output logic [31:0]           alu_operand1,
    output logic [31:0]           alu_operand2,
    output logic [3:0]            alu_opcode,
    input  logic [32:0]           alu_result,
    output logic                  busy
);
    localparam int GW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, last_grant_q, last_grant_d, gnt, idx;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   alu_operand1_q, alu_operand1_d, alu_operand2_q, alu_operand2_d;
    logic [3:0]    alu_opcode_q, alu_opcode_d, gnt_opcode;
    logic [32:0]   result_q, result_d;
    logic          error_q, error_d, busy_q, busy_d, legal;

    // Later iterations are closer to last_grant+1, so they win.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = GW'((int'(last_grant_q) + i) % NUM_REQ);
            gnt = req_valid[idx] ? idx : gnt;
        end
    end

    assign gnt_opcode = req_opcode[{gnt, 2'b00} +: 4];
    assign legal      = !gnt_opcode[3] && |gnt_opcode[2:0];

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        cnt_d          = cnt_q;
        alu_operand1_d = alu_operand1_q;
        alu_operand2_d = alu_operand2_q;
        alu_opcode_d   = alu_opcode_q;
        result_d       = result_q;
        error_d        = error_q;
        case (state_q)
            IDLE: if (|req_valid) begin
                grant_d = gnt;
                if (legal) begin
                    alu_operand1_d = req_operand1[{gnt, 5'b0} +: 32];
                    alu_operand2_d = req_operand2[{gnt, 5'b0} +: 32];
                    alu_opcode_d   = gnt_opcode;
                    cnt_d          = 3'(ALU_LATENCY);
                    state_d        = EXEC;
                end else begin
                    result_d = '0;
                    error_d  = 1'b1;
                    state_d  = RESP;
                end
            end
            EXEC: if (cnt_q == '0) begin
                result_d       = alu_result;
                error_d        = 1'b0;
                alu_operand1_d = '0;
                alu_operand2_d = '0;
                alu_opcode_d   = '0;
                state_d        = RESP;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
            RESP: if (resp_ready[grant_q]) begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            last_grant_q   <= GW'(NUM_REQ - 1);
            cnt_q          <= '0;
            alu_operand1_q <= '0;
            alu_operand2_q <= '0;
            alu_opcode_q   <= '0;
            result_q       <= '0;
            error_q        <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
            alu_operand1_q <= alu_operand1_d;
            alu_operand2_q <= alu_operand2_d;
            alu_opcode_q   <= alu_opcode_d;
            result_q       <= result_d;
            error_q        <= error_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ready    = (state_q == IDLE && !reset && |req_valid) ? NUM_REQ'(1) << gnt : '0;
    assign resp_valid   = (state_q == RESP) ? NUM_REQ'(1) << grant_q : '0;
    assign resp_result  = result_q;
    assign resp_error   = error_q;
    assign alu_operand1 = alu_operand1_q;
    assign alu_operand2 = alu_operand2_q;
    assign alu_opcode   = alu_opcode_q;
    assign busy         = busy_q;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one clocked `alu` instance between `NUM_REQ` requesters. Each requester presents an operand pair and opcode with a valid/ready handshake. The arbiter picks one round-robin, drives the ALU inputs for the required cycles, captures the 33-bit result and returns it through a per-requester response handshake. It sits between the ALU and its clients (decode/issue, address generation) and is the only block that drives ALU inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ALU_LATENCY`, 1: clocks from ALU inputs first presented to `alu_result` valid, 1..4.

- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_ready` out NUM_REQ: request accepted this cycle (one-hot or zero).
- `req_operand1` in 32*NUM_REQ: requester i at [32*i+31:32*i].
- `req_operand2` in 32*NUM_REQ: same packing.
- `req_opcode` in 4*NUM_REQ: requester i at [4*i+3:4*i].
- `resp_valid` out NUM_REQ: response for requester i (one-hot or zero).
- `resp_ready` in NUM_REQ: requester consumes response.
- `resp_result` out 33: shared result bus; bit 32 is the ALU carry/borrow.
- `resp_error` out 1: qualified by `resp_valid`; set for an illegal opcode.
- `alu_operand1`, `alu_operand2` out 32: ALU operands, registered.
- `alu_opcode` out 4: ALU opcode, registered; 4'b0000 when no operation is in flight.
- `alu_result` in 33: ALU output.
- `busy` out 1: high in every state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE.** If any `req_valid` is set, grant g is the first set bit searching upward from `last_grant+1` modulo NUM_REQ.
  - `req_ready[g]` is combinational and asserted only in IDLE.
  - The accept edge latches g, the operands and the opcode.
- **Legal opcode** (4'b0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 SLL, 0111 SRL):
  - At the accept edge, `alu_*` load the latched values and the FSM enters EXEC with `cnt` = ALU_LATENCY.
- **Illegal opcode** (0000 and 1000..1111):
  - The ALU is not driven; `alu_opcode` stays 0000.
  - The result register loads 0, the error flag is set, and the FSM goes directly to RESP.
- **EXEC.** `alu_*` are held constant. `cnt` decrements each cycle.
  - When `cnt` == 0, the edge captures `alu_result` unmodified into the result register, clears the error flag, returns `alu_operand1`, `alu_operand2` and `alu_opcode` to 0, and enters RESP.
- **RESP.** `resp_valid[g]` = 1; `resp_result` and `resp_error` come from registers and are stable.
  - When `resp_ready[g]` is high: `last_grant` ← g, state ← IDLE.
  - `resp_ready` bits for other requesters are ignored.
- Exactly one transaction is in flight at a time; `req_ready` is all-zero outside IDLE.
- Requesters must hold `req_valid` and request fields stable until accepted.
  - Fields may change freely after the accept edge; latched copies are used.
  - Dropping `req_valid` before acceptance withdraws the request with no side effects.
- **Reset** (at any point, including mid-EXEC or mid-RESP):
  - State IDLE; `last_grant` = NUM_REQ-1, so requester 0 has first priority.
  - Any in-flight transaction is dropped and no response is issued.
  - All outputs are 0: `req_ready`, `resp_valid`, `resp_result`, `resp_error`, `alu_operand1`, `alu_operand2`, `alu_opcode`, `busy`.

## Timing
- Accept in cycle 0 (IDLE).
- `alu_*` are valid in cycles 1..ALU_LATENCY+1.
- `alu_result` is captured at the end of cycle ALU_LATENCY+1.
- `resp_valid` rises in cycle ALU_LATENCY+2 (cycle 3 for the default).
- Illegal opcode: `resp_valid` in cycle 1.
- Response handshake completes on the cycle `resp_ready[g]` is high; the next cycle is IDLE.
  - IDLE lasts at least one cycle, so there is no accept in the same cycle as the response handshake.
  - Best-case throughput is one legal operation per ALU_LATENCY+3 cycles.
- Round-robin wrap: after a grant to NUM_REQ-1, search starts at 0.
- Simultaneous requests are resolved purely by the round-robin order above; a requester with continuous `req_valid` cannot be starved beyond NUM_REQ-1 other grants.
- `busy` = (state != IDLE), registered with the state.

## Test plan
- **Reset:** hold `reset` 3 cycles with all `req_valid` high → all outputs 0 and `req_ready` 0 during reset. The first cycle after release grants requester 0.
- **Single ADD:** requester 0 ADD, operands 50,10, ALU_LATENCY=1 → `alu_opcode`=0001 in cycles 1..2, `resp_valid`=4'b0001 in cycle 3, `resp_result`=60, `resp_error`=0. Repeat with SUB, expecting 40.
- **Fairness:** all four `req_valid` held high, each with distinct opcodes → grant order 0,1,2,3. Then requesters 0 and 2 re-request → order 0,2. No requester is granted twice before another pending requester is granted.
- **Backpressure:** `resp_ready` low for 5 cycles during RESP → `resp_valid`, `resp_result` and `resp_error` are held constant. `req_ready` stays 0 for all requesters despite pending requests.
- **Illegal opcode:** requester 1, opcode 4'b1000 → `resp_valid[1]` in cycle 1, `resp_error`=1, `resp_result`=0, `alu_opcode` remains 0000 throughout.
- **Reset mid-EXEC:** assert `reset` in EXEC cycle 1 → no `resp_valid` ever for that request, `alu_opcode`=0000 the cycle after reset. The next grant goes to requester 0.
